// File: rtl/mem_access_ctrl_if.sv
// Core-side request/response and memory-side handshake bundle for mem_access_ctrl.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_base;
  logic [3:0]        req_imm;
  logic [DATA_W-1:0] req_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              stall;

  modport slave (
    input  req_valid, req_we, req_base, req_imm, req_wdata, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_rdata,
           rsp_err, stall
  );

  modport master (
    output req_valid, req_we, req_base, req_imm, req_wdata, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_rdata,
           rsp_err, stall
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: registers base+offset address, runs a bounded-wait memory
// handshake and returns exactly one response (data or timeout) per accepted request.
module mem_access_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [7:0]        cnt_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_err_r;
  logic [ADDR_W-1:0] eff_addr_s;
  logic              timeout_s;

  assign eff_addr_s = bus.req_base + {{(ADDR_W-4){bus.req_imm[3]}}, bus.req_imm};
  assign timeout_s  = (cnt_r == 8'(TIMEOUT - 1));

  // Next-state selection; an ack on the last allowed cycle still counts as success
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) state_next_s = ACCESS;
        else               state_next_s = IDLE;
      end
      ACCESS: begin
        if (bus.mem_ack || timeout_s) state_next_s = RESP;
        else                          state_next_s = ACCESS;
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, memory-side and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      rsp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            mem_addr_r  <= eff_addr_s;
            mem_wdata_r <= bus.req_wdata;
            mem_we_r    <= bus.req_we;
            cnt_r       <= 8'd0;
            mem_req_r   <= 1'b1;
          end
        end
        ACCESS: begin
          if (bus.mem_ack) begin
            rsp_rdata_r <= mem_we_r ? {DATA_W{1'b0}} : bus.mem_rdata;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
          end else if (timeout_s) begin
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        RESP: begin
          mem_req_r <= 1'b0;
        end
        default: begin
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = (state_r == IDLE);
  assign bus.stall     = (state_r != IDLE);
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencer for data-memory load/store accesses in the 16-bit CPU.
- Accepts a request from the core: base register value, 4-bit signed offset, store data and direction.
- Forms the effective address as base + sign-extended offset, which is the same arithmetic SignExtend_M performs.
- Drives a variable-latency memory handshake, stalls the core while busy, and returns one response per request, with a timeout error if memory never acknowledges.

Parameters:
- ADDR_W, 16, address width; effective address wraps modulo 2^ADDR_W.
- DATA_W, 16, data width.
- TIMEOUT, 15, maximum number of ACCESS cycles to wait for mem_ack; valid range is 1..255.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  controller can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_base  input  ADDR_W  base register value.
- req_imm  input  4  signed offset, two's complement.
- req_wdata  input  DATA_W  store data.
- mem_req  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  effective address.
- mem_wdata  output  DATA_W  store data to memory.
- mem_ack  input  1  memory completion.
- mem_rdata  input  DATA_W  load data, valid when mem_ack is high.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  DATA_W  load result; 0 for stores and on error.
- rsp_err  output  1  timeout flag; qualified by rsp_valid.
- stall  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values (on the rst edge): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. In this state req_ready=1 and stall=0.
- Reset mid-operation aborts any access immediately. No response is issued for the aborted request.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - req_ready=1.
  - When req_valid is high, the controller registers mem_addr = req_base + {{12{req_imm[3]}}, req_imm} (modulo 2^16, carry discarded), mem_wdata = req_wdata and mem_we = req_we, clears the counter, and moves to ACCESS.
  - When req_valid is low, the controller stays in IDLE.
- ACCESS:
  - mem_req=1. mem_addr, mem_we and mem_wdata are held stable.
  - If mem_ack=1: capture rsp_rdata = (mem_we ? 0 : mem_rdata), set rsp_err=0, go to RESP.
  - Else if counter == TIMEOUT-1: set rsp_err=1 and rsp_rdata=0, go to RESP.
  - Else: increment the counter.
  - mem_ack on the final timeout cycle counts as success; ack wins over timeout.
- RESP:
  - mem_req=0, mem_we=0, rsp_valid=1 for exactly one cycle, then IDLE.
  - rsp_rdata and rsp_err hold until the next response.
- mem_ack outside ACCESS is ignored.
- Latency: request accepted at edge N, mem_req high in cycle N+1. An ack sampled at edge N+k (k≥1) gives rsp_valid in cycle N+k+1. The minimum request-to-response time is 2 cycles.
- Throughput: at most one outstanding request. A new request can be accepted on the first IDLE cycle after RESP, so back-to-back requests are spaced 3 cycles at best.
- req_valid high while req_ready=0 is not accepted. The core holds its request under stall.

Test Plan:
- Load with positive offset: base=0x0100, imm=4'b0011, ack on first ACCESS cycle with mem_rdata=0xBEEF -> mem_addr=0x0103, mem_we=0, rsp_valid 2 cycles after accept, rsp_rdata=0xBEEF, rsp_err=0.
- Negative offset and wrap-around:
  - base=0x0100, imm=4'b1100 -> mem_addr=0x00FC.
  - base=0x0002, imm=4'b1100 -> mem_addr=0xFFFE.
  - base=0xFFFF, imm=4'b0111 -> mem_addr=0x0006.
- Store with 3 wait states: req_we=1, wdata=0x1234, base=0x0040, imm=0, ack on the 4th ACCESS cycle -> mem_req high for 4 cycles with addr and data stable, stall high for 5 cycles, rsp_valid with rsp_rdata=0 and rsp_err=0.
- Timeout at TIMEOUT=15 with no ack -> mem_req high for exactly 15 cycles, then rsp_valid with rsp_err=1 and rsp_rdata=0. A repeat run with ack on the 15th cycle -> rsp_err=0.
- Reset mid-ACCESS: rst asserted at the 2nd wait cycle -> next cycle mem_req=0, req_ready=1, stall=0, no rsp_valid. A following load completes normally.
- Back-to-back: req_valid held high across two requests -> second accept occurs in the IDLE cycle after RESP. Two distinct rsp_valid pulses with correct data, and a stray mem_ack during IDLE is ignored.
